if_stage: RTL

- Pipelined instruction-fetch stage for the MIPS core; sits directly upstream of the decode/register-read logic (Control, Registers, Sign_Extend).
- Owns the PC register and the IF/ID pipeline register.
- Issues fetch requests to a variable-latency instruction memory using a req/ack handshake.
- Handles decode-stage stall (load-use) and flush/redirect (taken branch or jump resolved in ID).

---
 rtl/if_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches through a
// req/ack memory port, and absorbs decode stalls (skid buffer) and redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HELD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pendingPc;
  logic [31:0] r_skid;
  logic [31:0] r_inst;
  logic [31:0] r_pcPlus4;
  logic        r_valid;
  logic        r_req;
  logic [31:0] w_pcPlus4;

  assign w_pcPlus4 = r_pc + 32'd4;

  // In DRAIN the PC is left untouched, so r_pc is also the killed in-flight address.
  assign imem_addr_o = r_pc;
  assign imem_req_o  = r_req;
  assign inst_o      = r_valid ? r_inst : INST_NOP;
  assign pc_plus4_o  = r_pcPlus4;
  assign valid_o     = r_valid;

  // Redirects take priority over everything; a stall only freezes IF/ID.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_pendingPc <= RESET_PC;
      r_skid      <= INST_NOP;
      r_inst      <= INST_NOP;
      r_pcPlus4   <= 32'd0;
      r_valid     <= 1'b0;
      r_req       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end

        S_FETCH: begin
          if (flush_i) begin
            r_valid <= 1'b0;
            if (imem_ack_i) begin
              r_pc <= redirect_pc_i;
            end else begin
              r_pendingPc <= redirect_pc_i;
              r_state     <= S_DRAIN;
            end
          end else if (imem_ack_i) begin
            if (stall_i) begin
              r_skid  <= imem_data_i;
              r_state <= S_HELD;
              r_req   <= 1'b0;
            end else begin
              r_inst    <= imem_data_i;
              r_pcPlus4 <= w_pcPlus4;
              r_valid   <= 1'b1;
              r_pc      <= w_pcPlus4;
            end
          end else if (!stall_i) begin
            r_valid <= 1'b0;
          end
        end

        S_HELD: begin
          if (flush_i) begin
            r_pc    <= redirect_pc_i;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else if (!stall_i) begin
            r_inst    <= r_skid;
            r_pcPlus4 <= w_pcPlus4;
            r_valid   <= 1'b1;
            r_pc      <= w_pcPlus4;
            r_state   <= S_FETCH;
            r_req     <= 1'b1;
          end
        end

        S_DRAIN: begin
          // The killed request's data is dropped; the latest redirect wins.
          if (imem_ack_i) begin
            r_pc    <= flush_i ? redirect_pc_i : r_pendingPc;
            r_state <= S_FETCH;
          end else if (flush_i) begin
            r_pendingPc <= redirect_pc_i;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
